// File: rtl/serial_eq_cmp_pkg.sv
// -----------------------------------------------------------------------------
// serial_eq_cmp_pkg
//   Shared project definitions for the serial equality comparator.
//   - FSM state encodings (IDLE/SHIFT/DONE). Kept here so every file that
//     decodes the comparator state uses the same values.
//   - idx_width(): width of a bit-index field for a given operand width.
// -----------------------------------------------------------------------------
package serial_eq_cmp_pkg;

    typedef logic [1:0] cmp_state_t;

    localparam cmp_state_t ST_IDLE  = 2'd0;
    localparam cmp_state_t ST_SHIFT = 2'd1;
    localparam cmp_state_t ST_DONE  = 2'd2;

    // Bits needed to hold an index 0..w-1; never less than one bit.
    function automatic int idx_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/my_eq.sv
// -----------------------------------------------------------------------------
// my_eq
//   1-bit equality cell.
//   Ports:
//     a, b : input bits
//     eq   : 1 when a == b
// -----------------------------------------------------------------------------
module my_eq (
    input  logic a,
    input  logic b,
    output logic eq
);

    assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_eq_cmp.sv
// -----------------------------------------------------------------------------
// serial_eq_cmp
//   Bit-serial equality comparator. On an accepted start the two operands are
//   captured and compared one bit per clock, MSB first. The first differing
//   bit ends the comparison early and its index is reported.
//
//   Ports:
//     clk     : clock, rising edge
//     rst_n   : asynchronous active-low reset
//     start   : begin a comparison (accepted only while idle)
//     a, b    : operands, captured on the accepting edge
//     busy    : comparison in progress (SHIFT or DONE)
//     done    : one-cycle pulse, result valid from this cycle
//     eq      : 1 = operands equal, 0 = mismatch found
//     mis_idx : index of the most significant mismatching bit (0 if equal)
// -----------------------------------------------------------------------------
module serial_eq_cmp
    import serial_eq_cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [WIDTH-1:0]          a,
    input  logic [WIDTH-1:0]          b,
    output logic                      busy,
    output logic                      done,
    output logic                      eq,
    output logic [$clog2(WIDTH)-1:0]  mis_idx
);

    localparam int IW = $clog2(WIDTH);

    cmp_state_t       state_reg;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] b_sh_reg;
    logic [IW-1:0]    cnt_reg;
    logic             busy_reg;
    logic             done_reg;
    logic             eq_reg;
    logic [IW-1:0]    mis_idx_reg;
    logic             bit_eq;

    // The bit under test is always the MSB: operands are shifted left once
    // per SHIFT cycle, so cnt_reg tracks which original bit sits there.
    my_eq u_bit_eq (
        .a  (a_sh_reg[WIDTH-1]),
        .b  (b_sh_reg[WIDTH-1]),
        .eq (bit_eq)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_IDLE;
            a_sh_reg    <= '0;
            b_sh_reg    <= '0;
            cnt_reg     <= '0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
            eq_reg      <= 1'b0;
            mis_idx_reg <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    if (start) begin
                        a_sh_reg    <= a;
                        b_sh_reg    <= b;
                        cnt_reg     <= IW'(WIDTH - 1);
                        eq_reg      <= 1'b0;
                        mis_idx_reg <= '0;
                        busy_reg    <= 1'b1;
                        state_reg   <= ST_SHIFT;
                    end
                end

                ST_SHIFT: begin
                    if (!bit_eq) begin
                        // Early exit on the first (most significant) difference.
                        eq_reg      <= 1'b0;
                        mis_idx_reg <= cnt_reg;
                        done_reg    <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else if (cnt_reg == '0) begin
                        eq_reg      <= 1'b1;
                        mis_idx_reg <= '0;
                        done_reg    <= 1'b1;
                        state_reg   <= ST_DONE;
                    end else begin
                        cnt_reg  <= cnt_reg - IW'(1);
                        a_sh_reg <= {a_sh_reg[WIDTH-2:0], 1'b0};
                        b_sh_reg <= {b_sh_reg[WIDTH-2:0], 1'b0};
                    end
                end

                ST_DONE: begin
                    // start is deliberately not examined here: a new request
                    // is only taken once the FSM is back in IDLE.
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end

                default: begin
                    done_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_reg;
    assign done    = done_reg;
    assign eq      = eq_reg;
    assign mis_idx = mis_idx_reg;

endmodule

// File: tb/tb_serial_eq_cmp.sv
// -----------------------------------------------------------------------------
// tb_serial_eq_cmp
//   Self-checking bench for serial_eq_cmp (WIDTH=8). A transaction-level model
//   predicts busy/done/eq/mis_idx each cycle; directed vectors add literal
//   expectations for latency and results.
// -----------------------------------------------------------------------------
module tb_serial_eq_cmp;

    localparam int W = 8;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic         busy;
    logic         done;
    logic         eq;
    logic [2:0]   mis_idx;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_eq_cmp #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .eq      (eq),
        .mis_idx (mis_idx)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference result: highest differing bit decides everything.
    function automatic void ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                       output int lat, output int r_eq, output int r_idx);
        lat   = W;
        r_eq  = 1;
        r_idx = 0;
        for (int j = 0; j < W; j++) begin
            if (x[j] != y[j]) begin
                lat   = W - j;
                r_eq  = 0;
                r_idx = j;
            end
        end
    endfunction

    // ---------------- transaction model ----------------
    // An operation accepted at edge k occupies edges k..k+L (busy), pulses
    // done after edge k+L, and the edge k+L+1 only returns to idle.
    int m_n      = 0;
    int m_k      = 0;
    int m_lat    = 0;
    int m_req    = 0;
    int m_ridx   = 0;
    bit m_active = 0;
    int m_busy   = 0;
    int m_done   = 0;
    int m_eq     = 0;
    int m_idx    = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_n = 0; m_active = 0; m_busy = 0; m_done = 0; m_eq = 0; m_idx = 0;
        end else begin
            m_n++;
            if (m_active && m_n == m_k + m_lat + 1) begin
                m_active = 0;
            end else if (!m_active && start) begin
                m_active = 1;
                m_k      = m_n;
                ref_result(a, b, m_lat, m_req, m_ridx);
                m_eq     = 0;
                m_idx    = 0;
            end
            m_busy = m_active ? 1 : 0;
            m_done = (m_active && m_n == m_k + m_lat) ? 1 : 0;
            if (m_done == 1) begin
                m_eq  = m_req;
                m_idx = m_ridx;
            end
        end
    end

    always @(negedge clk) begin
        chk("cyc_busy",    int'(busy),    m_busy);
        chk("cyc_done",    int'(done),    m_done);
        chk("cyc_eq",      int'(eq),      m_eq);
        chk("cyc_mis_idx", int'(mis_idx), m_idx);
    end

    // ---------------- directed stimulus ----------------
    // Called at a negedge with the DUT idle; returns at a negedge, DUT idle.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input int exp_lat, input int exp_eq, input int exp_idx,
                          input string name);
        int lat;
        bit seen;
        a = av; b = bv; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        a = W'($urandom);           // operands must be ignored after capture
        b = W'($urandom);
        seen = 0;
        lat  = -1;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                lat  = i;
                chk({name, "_eq"},  int'(eq),      exp_eq);
                chk({name, "_idx"}, int'(mis_idx), exp_idx);
            end
        end
        chk({name, "_lat"}, lat, exp_lat);
        @(negedge clk);
        chk({name, "_pulse1"}, int'(done), 0);
        chk({name, "_idle"},   int'(busy), 0);
        $display("op %s a=%02h b=%02h lat=%0d eq=%0d idx=%0d", name, av, bv, lat, eq, mis_idx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_done;
        int last;
        int first;
        int cap_eq;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_eq",   int'(eq),   0);
        chk("rst_idx",  int'(mis_idx), 0);
        rst_n = 1'b1;

        // Directed vectors (first one accepted on the first edge after reset)
        run_op(8'hA5, 8'hA5, 8, 1, 0, "a5_a5");
        run_op(8'h80, 8'h00, 1, 0, 7, "80_00");
        run_op(8'h01, 8'h00, 8, 0, 0, "01_00");
        run_op(8'h0F, 8'h1F, 4, 0, 4, "0f_1f");
        run_op(8'hFF, 8'h7F, 1, 0, 7, "ff_7f");
        run_op(8'hC3, 8'hC7, 6, 0, 2, "c3_c7");
        run_op(8'h00, 8'h00, 8, 1, 0, "00_00");

        // Result holds while idle
        repeat (3) @(negedge clk);
        chk("hold_eq",  int'(eq),      1);
        chk("hold_idx", int'(mis_idx), 0);

        // Start while busy is ignored
        a = 8'h3C; b = 8'h3C; start = 1'b1;
        @(posedge clk);
        #2;
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        cnt_done = 0;
        cap_eq   = -1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) begin
                cnt_done++;
                cap_eq = int'(eq);
            end
        end
        chk("ign_done_cnt", cnt_done, 1);
        chk("ign_eq",       cap_eq,   1);
        $display("op ignore_busy dones=%0d eq=%0d", cnt_done, cap_eq);

        // Reset mid-comparison
        a = 8'hFF; b = 8'hFF; start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_eq",   int'(eq),   0);
        chk("abort_idx",  int'(mis_idx), 0);
        $display("op abort busy=%0d done=%0d eq=%0d idx=%0d", busy, done, eq, mis_idx);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'h12, 8'h13, 8, 0, 0, "12_13");

        // Back-to-back with start held high: one idle cycle between ops
        a = 8'h55; b = 8'h55; start = 1'b1;
        cnt_done = 0;
        last     = -1;
        first    = -1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (done) begin
                if (last >= 0) chk("b2b_gap", i - last, 10);
                else first = i;
                last = i;
                cnt_done++;
            end
        end
        start = 1'b0;
        chk("b2b_first", first, 8);
        chk("b2b_count", cnt_done, 4);
        $display("op back_to_back dones=%0d first=%0d", cnt_done, first);
        for (int i = 0; i < 20 && busy; i++) @(negedge clk);
        chk("b2b_quiet", int'(busy), 0);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/serial_eq_cmp.md
SERIAL_EQ_CMP -- requirements
Module: serial_eq_cmp

Interface
REQ-001 Parameter: WIDTH, default 8, operand width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a comparison; sampled only in IDLE.
REQ-005 a  input  WIDTH  first operand; sampled with start.
REQ-006 b  input  WIDTH  second operand; sampled with start.
REQ-007 busy  output  1  high while a comparison is in progress (states SHIFT and DONE).
REQ-008 done  output  1  one-cycle pulse; the result is valid from this cycle.
REQ-009 eq  output  1  1 = operands equal, 0 = mismatch found.
REQ-010 mis_idx  output  clog2(WIDTH)  bit index of the first (most significant) mismatching bit; 0 when eq=1.

Function
REQ-011 The FSM SHALL have exactly three states: IDLE, SHIFT, DONE.
REQ-012 IDLE: on a rising edge with start=1, the block SHALL latch a and b into internal shift registers, load bit counter cnt=WIDTH-1, clear eq and mis_idx, and enter SHIFT.
REQ-013 SHIFT: on each edge, the block SHALL compare one bit pair, starting at the MSB (index cnt), one bit per cycle.
REQ-014 SHIFT, bits differ: eq<=0, mis_idx<=cnt, next state DONE (early termination).
REQ-015 SHIFT, bits equal and cnt=0: eq<=1, mis_idx<=0, next state DONE.
REQ-016 SHIFT, bits equal and cnt>0: cnt<=cnt-1, stay in SHIFT.
REQ-017 DONE: done=1 for exactly this one cycle; unconditional transition to IDLE on the next edge.
REQ-018 Latency: start sampled at edge k, mismatch at bit j -> done high in the cycle after edge k+(WIDTH-j); full match -> done high in the cycle after edge k+WIDTH.
REQ-019 busy, done, eq and mis_idx SHALL be registered outputs (no combinational path from inputs).
REQ-020 start while busy=1 SHALL be ignored; no queuing.
REQ-021 start in the same cycle that the FSM is in DONE SHALL be ignored; a new start is accepted from IDLE only.
REQ-022 eq and mis_idx SHALL hold their values from DONE until the next accepted start.
REQ-023 Changes on a and b after the start edge SHALL NOT affect the result.

Reset
REQ-024 With rst_n=0, the block SHALL go to IDLE immediately (asynchronously): busy=0, done=0, eq=0, mis_idx=0, cnt=0, operand registers=0.
REQ-025 Reset mid-comparison SHALL abort the operation; no done pulse is generated for it.
REQ-026 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-027 The state encodings (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) SHALL be localparams in the shared project header include file and SHALL NOT be repeated locally.
REQ-028 The per-bit comparison SHALL instantiate the existing 1-bit equality cell my_eq on the MSBs of the two shift registers; no new sub-module is created.
REQ-029 Bit selection SHALL be done by left-shifting both operand registers once per SHIFT cycle; dynamic indexing is not used.

Verification (WIDTH=8)
REQ-030 a=8'hA5, b=8'hA5, start for 1 cycle -> busy rises, done pulses after 8 edges in SHIFT, eq=1, mis_idx=0.
REQ-031 a=8'h80, b=8'h00 -> done after 1 SHIFT edge, eq=0, mis_idx=7.
REQ-032 a=8'h01, b=8'h00 -> done after 8 SHIFT edges, eq=0, mis_idx=0.
REQ-033 a=8'h3C, b=8'h3C start; in the next cycle, a=8'hFF, b=8'h00, start=1 again -> second start ignored, result eq=1, exactly one done pulse.
REQ-034 Start a=8'hFF, b=8'hFF; rst_n=0 for 1 cycle after the 3rd SHIFT edge -> all outputs 0 immediately, no done; next start a=8'h12, b=8'h13 -> eq=0, mis_idx=0.
REQ-035 Back-to-back: start asserted continuously -> a new comparison is accepted on the edge after each done cycle; done pulses never merge.
